// File: rtl/mfcc_seq_pkg.sv
// Shared definitions for the MFCC delta / delta-delta tap sequencers:
// state encoding, coefficient width rule and the edge-clamp helper.
package mfcc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Signed width able to hold -K..+K.
    function automatic int coef_width(input int k);
        return $clog2(k + 1) + 1;
    endfunction

    // Clamp a signed frame index into [0, hi].
    function automatic int clamp_index(input int v, input int hi);
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/delta_tap_clamp.sv
// Combinational tap address: centre + signed offset, clamped to the
// valid frame range [0, frame_total-1].
module delta_tap_clamp
    import mfcc_seq_pkg::*;
#(
    parameter int CNT_W  = 7,
    parameter int COEF_W = 3
) (
    input  logic [CNT_W-1:0]        centre,
    input  logic signed [COEF_W-1:0] offset,
    input  logic [CNT_W-1:0]        frame_total,
    output logic [CNT_W-1:0]        addr
);

    localparam int SUM_W = CNT_W + 2;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] hi;
    int                      clamped;

    always_comb begin
        sum     = $signed({2'b00, centre}) + SUM_W'(offset);
        hi      = $signed({2'b00, frame_total}) - SUM_W'(1);
        clamped = clamp_index(int'(sum), int'(hi));
        addr    = clamped[CNT_W-1:0];
    end

endmodule

// File: rtl/delta_window_sequencer.sv
// Window-aware frame/tap sequencer for the delta stages: waits for enough
// lookahead frames per centre, then streams 2K+1 clamped taps over ready/valid.
module delta_window_sequencer
    import mfcc_seq_pkg::*;
#(
    parameter int  CNT_W  = 7,
    parameter int  WIN_K  = 2,
    localparam int COEF_W = coef_width(WIN_K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         frame_total,
    input  logic                     frame_tick,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic [CNT_W-1:0]         tap_frame,
    output logic signed [COEF_W-1:0] tap_coef,
    output logic                     tap_last,
    output logic [CNT_W-1:0]         centre_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int NEED_W = CNT_W + 2;
    localparam logic signed [COEF_W-1:0] K_POS = COEF_W'(WIN_K);
    localparam logic signed [COEF_W-1:0] K_NEG = -K_POS;

    seq_state_t state_reg, state_next;

    logic [CNT_W-1:0]         n_reg, n_next;
    logic [CNT_W-1:0]         frames_reg, frames_next;
    logic [CNT_W-1:0]         c_reg, c_next;
    logic signed [COEF_W-1:0] t_reg, t_next;

    logic                     tap_valid_reg;
    logic [CNT_W-1:0]         tap_frame_reg;
    logic signed [COEF_W-1:0] tap_coef_reg;
    logic                     tap_last_reg;
    logic [CNT_W-1:0]         centre_idx_reg;
    logic                     busy_reg;
    logic                     done_reg;

    logic [NEED_W-1:0]        need_raw;
    logic [CNT_W-1:0]         need;
    logic                     tap_fire;
    logic [CNT_W-1:0]         addr_next;

    // Frames required before centre c can be emitted: c+K+1, capped at N so
    // the trailing centres flush without further upstream ticks.
    always_comb begin
        need_raw = {2'b00, c_reg} + NEED_W'(WIN_K + 1);
        need     = (need_raw > {2'b00, n_reg}) ? n_reg : need_raw[CNT_W-1:0];
        tap_fire = tap_valid_reg & tap_ready;
    end

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        frames_next = frames_reg;
        c_next      = c_reg;
        t_next      = t_reg;

        if ((state_reg == ST_WAIT || state_reg == ST_TAP) &&
            frame_tick && (frames_reg < n_reg)) begin
            frames_next = frames_reg + CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    n_next      = frame_total;
                    frames_next = '0;
                    c_next      = '0;
                    state_next  = (frame_total == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (frames_reg >= need) begin
                    state_next = ST_TAP;
                    t_next     = K_NEG;
                end
            end
            ST_TAP: begin
                if (tap_fire) begin
                    if (t_reg != K_POS) begin
                        t_next = t_reg + COEF_W'(1);
                    end else if (c_reg == n_reg - CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end else begin
                        c_next     = c_reg + CNT_W'(1);
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    delta_tap_clamp #(
        .CNT_W  (CNT_W),
        .COEF_W (COEF_W)
    ) u_clamp (
        .centre      (c_next),
        .offset      (t_next),
        .frame_total (n_next),
        .addr        (addr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            n_reg      <= '0;
            frames_reg <= '0;
            c_reg      <= '0;
            t_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            n_reg      <= n_next;
            frames_reg <= frames_next;
            c_reg      <= c_next;
            t_reg      <= t_next;
        end
    end

    // Outputs are registered from next-state values so tap_valid has no
    // combinational dependence on tap_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_valid_reg  <= 1'b0;
            tap_frame_reg  <= '0;
            tap_coef_reg   <= '0;
            tap_last_reg   <= 1'b0;
            centre_idx_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            tap_valid_reg  <= (state_next == ST_TAP);
            tap_frame_reg  <= (state_next == ST_TAP) ? addr_next : '0;
            tap_coef_reg   <= (state_next == ST_TAP) ? t_next : '0;
            tap_last_reg   <= (state_next == ST_TAP) && (t_next == K_POS);
            centre_idx_reg <= c_next;
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
        end
    end

    assign tap_valid  = tap_valid_reg;
    assign tap_frame  = tap_frame_reg;
    assign tap_coef   = tap_coef_reg;
    assign tap_last   = tap_last_reg;
    assign centre_idx = centre_idx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_delta_window_sequencer.sv
// Self-checking bench for delta_window_sequencer (K=2, CNT_W=7): scoreboard of
// expected taps, table of utterance runs, and hand-written timing/reset cases.
module tb_delta_window_sequencer;
    import mfcc_seq_pkg::*;

    localparam int CNT_W  = 7;
    localparam int K      = 2;
    localparam int COEF_W = coef_width(K);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [CNT_W-1:0]         frame_total;
    logic                     frame_tick;
    logic                     tap_valid;
    logic                     tap_ready;
    logic [CNT_W-1:0]         tap_frame;
    logic signed [COEF_W-1:0] tap_coef;
    logic                     tap_last;
    logic [CNT_W-1:0]         centre_idx;
    logic                     busy;
    logic                     done;

    delta_window_sequencer #(.CNT_W(CNT_W), .WIN_K(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_total (frame_total),
        .frame_tick  (frame_tick),
        .tap_valid   (tap_valid),
        .tap_ready   (tap_ready),
        .tap_frame   (tap_frame),
        .tap_coef    (tap_coef),
        .tap_last    (tap_last),
        .centre_idx  (centre_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int frame;
        int coef;
        bit last;
        int centre;
    } tap_t;

    typedef struct {
        int n;
        int gap;
        bit rand_ready;
        bit abuse;
        int exp_taps;
    } vec_t;

    tap_t exp_q[$];
    int   log_frames[$];
    int   ref_log[$];
    int   checks = 0;
    int   failures = 0;
    int   tap_count;
    int   done_count;
    int   ticks_sent;
    int   cur_n;
    bit   rand_mode = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_clamp(input int v, input int n);
        if (v < 0) return 0;
        if (v > n - 1) return n - 1;
        return v;
    endfunction

    task automatic load_model(input int n);
        tap_t e;
        exp_q.delete();
        log_frames.delete();
        for (int c = 0; c < n; c++) begin
            for (int t = -K; t <= K; t++) begin
                e.frame  = model_clamp(c + t, n);
                e.coef   = t;
                e.last   = (t == K);
                e.centre = c;
                exp_q.push_back(e);
            end
        end
        tap_count  = 0;
        done_count = 0;
        ticks_sent = 0;
        cur_n      = n;
    endtask

    initial begin
        tap_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tap_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    bit   prev_stall, last_prev, done_prev;
    int   hold_frame, hold_coef, hold_last;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_stall = 0;
            last_prev  = 0;
            done_prev  = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(tap_valid), 1);
                check("hold_frame", int'(tap_frame), hold_frame);
                check("hold_coef", int'(tap_coef), hold_coef);
                check("hold_last", int'(tap_last), hold_last);
            end
            if (last_prev) check("done_after_last", int'(done), 1);
            if (done_prev) check("busy_after_done", int'(busy), 0);
            if (tap_valid) begin
                int need;
                need = int'(centre_idx) + K + 1;
                if (need > cur_n) need = cur_n;
                check("prime_gate", int'(ticks_sent >= need), 1);
            end
            if (tap_valid && tap_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_tap", tap_count, -1);
                end else begin
                    tap_t e;
                    e = exp_q.pop_front();
                    check("tap_frame", int'(tap_frame), e.frame);
                    check("tap_coef", int'(tap_coef), e.coef);
                    check("tap_last", int'(tap_last), int'(e.last));
                    check("centre_idx", int'(centre_idx), e.centre);
                end
                log_frames.push_back(int'(tap_frame));
                tap_count++;
            end
            if (done) done_count++;
            last_prev  = tap_valid && tap_ready && tap_last && (int'(centre_idx) == cur_n - 1);
            done_prev  = done;
            prev_stall = tap_valid && !tap_ready;
            hold_frame = int'(tap_frame);
            hold_coef  = int'(tap_coef);
            hold_last  = int'(tap_last);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(tap_valid), 0);
        check({tag, "_frame"}, int'(tap_frame), 0);
        check({tag, "_coef"}, int'(tap_coef), 0);
        check({tag, "_last"}, int'(tap_last), 0);
        check({tag, "_centre"}, int'(centre_idx), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic run(input vec_t v);
        int cycles;
        load_model(v.n);
        rand_mode = v.rand_ready;
        @(posedge clk); #1;
        start       = 1'b1;
        frame_total = CNT_W'(v.n);
        frame_tick  = v.abuse;
        @(posedge clk); #1;
        start      = 1'b0;
        frame_tick = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("no_tap_after_start", int'(tap_valid), 0);
        fork
            begin
                for (int i = 0; i < v.n + (v.abuse ? 10 : 0); i++) begin
                    repeat (v.gap - 1) @(posedge clk);
                    #1 frame_tick = 1'b1;
                    if (v.abuse && i == 1) begin
                        start       = 1'b1;
                        frame_total = CNT_W'(3);
                    end
                    @(posedge clk); #1;
                    frame_tick  = 1'b0;
                    start       = 1'b0;
                    frame_total = CNT_W'(v.n);
                    if (ticks_sent < v.n) ticks_sent++;
                end
            end
            begin
                cycles = 0;
                while (done_count == 0 && cycles < 3000) begin
                    @(posedge clk);
                    cycles++;
                end
                if (done_count == 0) check("done_timeout", cycles, -1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("tap_total", tap_count, v.exp_taps);
        check("done_once", done_count, 1);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        rand_mode = 1'b0;
    endtask

    vec_t vecs[7];
    int   win_exp[15];

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        frame_total = '0;
        frame_tick  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        load_model(0);
        mon_en = 1'b1;

        vecs[0] = '{n: 5, gap: 3, rand_ready: 0, abuse: 0, exp_taps: 25};
        vecs[1] = '{n: 5, gap: 3, rand_ready: 1, abuse: 0, exp_taps: 25};
        vecs[2] = '{n: 6, gap: 9, rand_ready: 0, abuse: 0, exp_taps: 30};
        vecs[3] = '{n: 1, gap: 1, rand_ready: 0, abuse: 0, exp_taps: 5};
        vecs[4] = '{n: 2, gap: 2, rand_ready: 1, abuse: 0, exp_taps: 10};
        vecs[5] = '{n: 7, gap: 2, rand_ready: 1, abuse: 1, exp_taps: 35};
        vecs[6] = '{n: 9, gap: 1, rand_ready: 0, abuse: 0, exp_taps: 45};
        win_exp = '{0, 0, 0, 1, 2, 0, 1, 2, 3, 4, 2, 3, 4, 4, 4};

        for (int i = 0; i < 7; i++) begin
            run(vecs[i]);
            $display("run %0d: n=%0d taps=%0d done=%0d", i, vecs[i].n, tap_count, done_count);
            if (i == 0) begin
                ref_log = log_frames;
                for (int j = 0; j < 5; j++) begin
                    if (log_frames.size() == 25) begin
                        check("win_c0", log_frames[j], win_exp[j]);
                        check("win_c2", log_frames[10 + j], win_exp[5 + j]);
                        check("win_c4", log_frames[20 + j], win_exp[10 + j]);
                    end
                end
            end
            if (i == 1) begin
                check("bp_len", log_frames.size(), ref_log.size());
                for (int j = 0; j < log_frames.size() && j < ref_log.size(); j++)
                    check("bp_same_seq", log_frames[j], ref_log[j]);
            end
        end

        // N==0: done at cycle 1, idle at cycle 2, no taps.
        load_model(0);
        @(posedge clk); #1;
        start       = 1'b1;
        frame_total = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("n0_done_c1", int'(done), 1);
        check("n0_busy_c1", int'(busy), 1);
        @(posedge clk); #1;
        check("n0_done_c2", int'(done), 0);
        check("n0_busy_c2", int'(busy), 0);
        check("n0_taps", tap_count, 0);
        $display("run n0: taps=%0d done=%0d", tap_count, done_count);

        // Reset in the middle of centre 3's taps, then a clean N=4 run.
        load_model(6);
        @(posedge clk); #1;
        start       = 1'b1;
        frame_total = CNT_W'(6);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            ticks_sent++;
        end
        begin
            int cyc;
            cyc = 0;
            while (!(tap_valid && centre_idx == CNT_W'(3)) && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            check("reach_c3", int'(centre_idx), 3);
        end
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        check_all_zero("rst_edge");
        rst = 1'b0;
        $display("run reset: taps before reset=%0d", tap_count);
        run('{n: 4, gap: 1, rand_ready: 0, abuse: 0, exp_taps: 20});
        $display("run after reset: n=4 taps=%0d done=%0d", tap_count, done_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delta_window_sequencer.md
# delta_window_sequencer

Parametrised frame/tap sequencer for the delta and delta-delta stages of the MFCC pipeline. It tracks how many cepstral frames have arrived from upstream for the current utterance. For each centre frame it then emits the 2K+1 tap addresses (edge-clamped) and the signed regression coefficients the delta datapath needs. It generalises the fixed-width, fixed-offset frame counter into a window-aware sequencer with programmable utterance length, lookahead priming, end-of-utterance flush and a ready/valid tap interface.

## Interface
- CNT_W, 7: width of frame counters and addresses.
- WIN_K, 2: delta window half-width K, 1..7.
- COEF_W, derived as $clog2(WIN_K+1)+1: signed coefficient width. Localparam, not overridable.

Ports:
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an utterance; ignored unless idle.
- frame_total  in  CNT_W  number of frames N; sampled on accepted start.
- frame_tick  in  1  one upstream frame has been written to the frame buffer.
- tap_valid  out  1  tap_frame / tap_coef valid.
- tap_ready  in  1  delta datapath accepts the tap.
- tap_frame  out  CNT_W  frame-buffer address, clamp(c+t, 0, N-1).
- tap_coef  out  COEF_W  signed offset t, -K..+K.
- tap_last  out  1  high with the t=+K tap of each centre.
- centre_idx  out  CNT_W  current centre frame c.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of utterance.

## Operation
- States: IDLE, WAIT, TAP, DONE.
- Reset: state IDLE. All outputs 0. Internal c, t and frames_in are 0.
- IDLE, start=1:
  - latch N and clear frames_in, c = 0.
  - If N==0, go to DONE; otherwise go to WAIT.
- frames_in increments on frame_tick in WAIT or TAP, saturating at N. Ticks in IDLE/DONE, and the tick in the start cycle, are ignored. Extra ticks beyond N are ignored.
- WAIT:
  - Go to TAP with t = -K once frames_in >= min(c+K+1, N).
  - This rule covers both lookahead priming (the first centre needs K+1 frames) and flush (the last K centres need no further ticks).
- TAP:
  - tap_valid=1.
  - tap_frame = clamp(c+t): computed with CNT_W+2-bit signed arithmetic, negative values clamp to 0, values >N-1 clamp to N-1.
  - tap_coef = t; tap_last = (t==+K).
  - On tap_valid & tap_ready with t<K: t increments.
  - With t==K:
    - if c==N-1, go to DONE;
    - else c increments and the block returns to WAIT.
- While tap_valid & !tap_ready, all tap outputs hold stable.
- DONE: done=1 for one cycle, then IDLE. busy falls in the IDLE cycle.
- start while busy: ignored, with no effect on N or counters.
- rst asserted mid-utterance: immediate return to reset values; no done pulse.

## Timing
- Accepted start at cycle 0: busy=1 and state WAIT from cycle 1.
- Condition met in WAIT at cycle n: tap_valid first high at cycle n+1.
- With tap_ready held high, the 2K+1 taps are on consecutive cycles. One WAIT cycle separates centres when frames are already available.
- Throughput: 2K+2 cycles per centre, steady state.
- Last tap accepted at cycle m: done=1 at m+1, busy=0 at m+2.
- N==0: done at cycle 1, busy=0 at cycle 2, no taps.
- All outputs are registered; there is no combinational path from tap_ready to tap_valid.

## Structure
- Shared package mfcc_seq_pkg holds:
  - the state enum;
  - the localparam COEF_W function;
  - a clamp helper function shared with the delta-1 sequencer.
- One sub-module: delta_tap_clamp (signed add of c+t plus clamp to [0, N-1]), purely combinational. Reused by the delta-1 sequencer.
- Top module holds the FSM, the frames_in, c and t counters, and the output registers.

## Test plan
- **Basic window.** K=2, N=5, five ticks spaced 3 cycles apart, ready=1 → taps:
  - c0: 0,0,0,1,2
  - c2: 0,1,2,3,4
  - c4: 2,3,4,4,4
  - coefs -2..2 each; tap_last on every fifth tap; done once; 25 taps total.
- **Priming/flush.** N=6, ticks delayed → no tap_valid before frames_in ≥ 3. After the 6th tick, centres 3..5 are emitted without further ticks.
- **Backpressure.** tap_ready toggled randomly → tap_frame/tap_coef stable while stalled. The tap sequence is identical to the ready=1 run.
- **Short utterances.**
  - N=0 → done at cycle 1, no taps.
  - N=1, K=2 → five taps, all address 0.
  - N=2 → addresses clamp at both ends.
- **Protocol abuse.** start pulsed while busy, 10 extra frame_ticks, and ticks in the start cycle → no change in sequence or count.
- **Reset mid-op.** rst asserted during TAP of c=3 → all outputs 0 next edge. A fresh start with N=4 runs cleanly from c=0.
